// File: rtl/priority_encoder_rr_if.sv
// ----------------------------------------------------------------------------
// priority_encoder_rr_if
//
// Bundles the request side and the registered grant side of
// priority_encoder_rr. Clock and reset are not part of the bundle; they stay
// plain ports on the encoder.
//
// Optional feature macro: PRIO_ENC_COUNT_EN adds the 16-bit grant_count signal.
//
// Signals:
//   enable      request source -> encoder : 1 = a load may produce a grant
//   mode        request source -> encoder : 0 = fixed priority, 1 = round-robin
//   data_in     request source -> encoder : request vector, bit i = request i
//   ready       consumer       -> encoder : consumer accepts the held grant
//   encoded_out encoder -> consumer       : registered binary index of the grant
//   onehot_out  encoder -> consumer       : registered one-hot of the grant
//   valid       encoder -> consumer       : outputs hold a grant
//   grant_count encoder -> consumer       : saturating handshake counter (optional)
//
// Modports:
//   master - the side that drives requests / ready (testbench, upstream logic)
//   slave  - the encoder itself
// ----------------------------------------------------------------------------
interface priority_encoder_rr_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OUT_W = $clog2(WIDTH);

    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic [OUT_W-1:0] encoded_out;
    logic [WIDTH-1:0] onehot_out;
    logic             valid;
`ifdef PRIO_ENC_COUNT_EN
    logic [15:0]      grant_count;
`endif

`ifdef PRIO_ENC_COUNT_EN
    modport master (
        output enable,
        output mode,
        output data_in,
        output ready,
        input  encoded_out,
        input  onehot_out,
        input  valid,
        input  grant_count
    );

    modport slave (
        input  enable,
        input  mode,
        input  data_in,
        input  ready,
        output encoded_out,
        output onehot_out,
        output valid,
        output grant_count
    );
`else
    modport master (
        output enable,
        output mode,
        output data_in,
        output ready,
        input  encoded_out,
        input  onehot_out,
        input  valid
    );

    modport slave (
        input  enable,
        input  mode,
        input  data_in,
        input  ready,
        output encoded_out,
        output onehot_out,
        output valid
    );
`endif

endinterface

// File: rtl/priority_encoder_rr.sv
// ----------------------------------------------------------------------------
// priority_encoder_rr
//
// Registered WIDTH-bit priority encoder with fixed or round-robin arbitration.
// The winning request is captured into a valid/ready output register, so the
// consumer can stall it; a stalled grant is held unchanged until accepted.
//
// Optional feature macro: PRIO_ENC_COUNT_EN adds a 16-bit saturating counter
// of accepted grants (valid && ready edges), visible as bus.grant_count.
//
// Parameters:
//   WIDTH   number of request lines (2..256, any value)
//
// Ports:
//   clk     single clock, all state updates on the rising edge
//   reset   synchronous active-low reset
//   bus     priority_encoder_rr_if.slave:
//             enable, mode, data_in, ready      (inputs)
//             encoded_out, onehot_out, valid    (registered outputs)
//             grant_count                       (registered, optional)
// ----------------------------------------------------------------------------
module priority_encoder_rr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    priority_encoder_rr_if.slave     bus
);

    localparam int unsigned OUT_W = $clog2(WIDTH);

    // Top index; the round-robin pointer wraps here explicitly so a
    // non-power-of-two WIDTH never reaches 2**OUT_W - 1.
    localparam logic [OUT_W-1:0] PtrMax = OUT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             valid_q,   valid_d;
    logic [OUT_W-1:0] enc_q,     enc_d;
    logic [WIDTH-1:0] onehot_q,  onehot_d;
    logic [OUT_W-1:0] ptr_q,     ptr_d;
`ifdef PRIO_ENC_COUNT_EN
    logic [15:0]      cnt_q,     cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Handshake / load strobes
    // ------------------------------------------------------------------------
    logic handshake;
    logic load;

    assign handshake = valid_q && bus.ready;
    assign load      = !valid_q || bus.ready;

    // ------------------------------------------------------------------------
    // Effective round-robin pointer
    //
    // When a grant is accepted in round-robin mode, the pointer moves to one
    // below the accepted index. The grant loaded on that same edge already
    // searches from the moved pointer, so a held all-ones request vector
    // walks 7,6,5,... with one grant per cycle instead of repeating indices.
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] ptr_eff;

    always_comb begin
        ptr_eff = ptr_q;
        if (handshake && bus.mode) begin
            if (enc_q == '0) begin
                ptr_eff = PtrMax;
            end else begin
                ptr_eff = enc_q - OUT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fixed priority: highest set index wins (later loop iterations override).
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] fix_idx;

    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bus.data_in[i]) begin
                fix_idx = OUT_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin: search ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1.
    //
    // Walk the search offsets from the farthest (WIDTH-1) to the nearest (0);
    // the last hit assigned is the one closest to ptr going downward.
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] rr_idx;
    logic [OUT_W-1:0] rr_cand;
    int               rr_pos;

    always_comb begin
        rr_idx  = '0;
        rr_cand = '0;
        rr_pos  = 0;
        for (int o = int'(WIDTH) - 1; o >= 0; o--) begin
            if (int'(ptr_eff) >= o) begin
                rr_pos = int'(ptr_eff) - o;
            end else begin
                rr_pos = int'(ptr_eff) + int'(WIDTH) - o;
            end
            rr_cand = OUT_W'(rr_pos);
            if (bus.data_in[rr_cand]) begin
                rr_idx = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic             any_req;
    logic [OUT_W-1:0] win_idx;
    logic [WIDTH-1:0] win_onehot;

    always_comb begin
        any_req    = |bus.data_in;
        win_idx    = bus.mode ? rr_idx : fix_idx;
        win_onehot = WIDTH'(1) << win_idx;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        enc_d    = enc_q;
        onehot_d = onehot_q;
        // ptr_eff equals ptr_q unless a round-robin handshake happens, so
        // fixed mode and stalls leave the pointer untouched.
        ptr_d    = ptr_eff;

        if (load) begin
            valid_d = bus.enable && any_req;
            if (any_req) begin
                enc_d    = win_idx;
                onehot_d = win_onehot;
            end else begin
                enc_d    = '0;
                onehot_d = '0;
            end
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            enc_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= PtrMax;
        end else begin
            valid_q  <= valid_d;
            enc_q    <= enc_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign bus.valid       = valid_q;
    assign bus.encoded_out = enc_q;
    assign bus.onehot_out  = onehot_q;
`ifdef PRIO_ENC_COUNT_EN
    assign bus.grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// ----------------------------------------------------------------------------
// tb_priority_encoder_rr
//
// Drives an 8-wide and a 5-wide encoder with shared control and separate
// request vectors. A reference model predicts the registered outputs when the
// stimulus is applied; predictions are queued and compared one edge later.
// Directed checks against fixed constants cover the documented scenarios.
// ----------------------------------------------------------------------------
module tb_priority_encoder_rr;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    priority_encoder_rr_if #(.WIDTH(8)) if8 ();
    priority_encoder_rr_if #(.WIDTH(5)) if5 ();

    priority_encoder_rr #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    priority_encoder_rr #(.WIDTH(5)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5)
    );

    typedef struct {
        bit v;
        int enc;
        int oh;
        int ptr;
        int cnt;
    } mstate_t;

    int total = 0;
    int bad   = 0;

    mstate_t m8, m5;
    mstate_t q8[$];
    mstate_t q5[$];

    bit         rn, en, md, rdy;
    logic [7:0] d8;
    logic [4:0] d5;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Winner by direct scan: fixed = highest set bit, round-robin = first set
    // bit walking downward from p with wrap at w-1.
    function automatic int pick(int w, int p, bit m, logic [7:0] d);
        if (!m) begin
            for (int i = w - 1; i >= 0; i--) if (d[i]) return i;
        end else begin
            for (int k = 0; k < w; k++) begin
                int idx;
                idx = (p - k + w) % w;
                if (d[idx]) return idx;
            end
        end
        return -1;
    endfunction

    function automatic mstate_t mnext(mstate_t s, int w, bit r_n, bit e, bit m,
                                      logic [7:0] d, bit r);
        mstate_t n;
        bit      hs;
        int      wi;
        n = s;
        if (!r_n) begin
            n.v = 0; n.enc = 0; n.oh = 0; n.ptr = w - 1; n.cnt = 0;
            return n;
        end
        hs = s.v && r;
        if (hs && s.cnt < 65535) n.cnt = s.cnt + 1;
        if (hs && m) n.ptr = (s.enc == 0) ? w - 1 : s.enc - 1;
        if (!s.v || r) begin
            wi    = pick(w, n.ptr, m, d);
            n.v   = e && (wi >= 0);
            n.enc = (wi >= 0) ? wi : 0;
            n.oh  = (wi >= 0) ? (1 << wi) : 0;
        end
        return n;
    endfunction

    // Apply current stimulus, predict, clock, then compare both DUTs.
    task automatic step();
        mstate_t e8, e5;
        reset       = rn;
        if8.enable  = en;  if8.mode = md;  if8.ready = rdy;  if8.data_in = d8;
        if5.enable  = en;  if5.mode = md;  if5.ready = rdy;  if5.data_in = d5;
        m8 = mnext(m8, 8, rn, en, md, d8, rdy);
        m5 = mnext(m5, 5, rn, en, md, {3'b000, d5}, rdy);
        q8.push_back(m8);
        q5.push_back(m5);
        @(posedge clk);
        #1;
        e8 = q8.pop_front();
        e5 = q5.pop_front();
        check_val("valid8", 32'(if8.valid),       32'(e8.v));
        check_val("enc8",   32'(if8.encoded_out), e8.enc);
        check_val("oh8",    32'(if8.onehot_out),  e8.oh);
        check_val("valid5", 32'(if5.valid),       32'(e5.v));
        check_val("enc5",   32'(if5.encoded_out), e5.enc);
        check_val("oh5",    32'(if5.onehot_out),  e5.oh);
`ifdef PRIO_ENC_COUNT_EN
        check_val("cnt8",   32'(if8.grant_count), e8.cnt);
`endif
    endtask

    int rr_exp[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int wrap_exp[4] = '{4, 0, 4, 0};

    initial begin
        m8 = '{v: 0, enc: 0, oh: 0, ptr: 7, cnt: 0};
        m5 = '{v: 0, enc: 0, oh: 0, ptr: 4, cnt: 0};

        // Reset held with all requests present
        rn = 0; en = 1; md = 0; rdy = 1; d8 = 8'hFF; d5 = 5'h1F;
        step();
        step();
        check_val("rst_valid", 32'(if8.valid), 0);
        check_val("rst_enc",   32'(if8.encoded_out), 0);
        check_val("rst_oh",    32'(if8.onehot_out), 0);

        rn = 1;
        step();
        check_val("first_enc", 32'(if8.encoded_out), 7);
        check_val("first_oh",  32'(if8.onehot_out), 32'h80);

        // Fixed priority
        d8 = 8'b0010_0110; d5 = 5'b00110;
        step();
        check_val("fix_enc",   32'(if8.encoded_out), 5);
        check_val("fix_oh",    32'(if8.onehot_out), 32'h20);
        check_val("fix_valid", 32'(if8.valid), 1);
        d8 = 8'h00; d5 = 5'h00;
        step();
        check_val("empty_valid", 32'(if8.valid), 0);
        check_val("empty_enc",   32'(if8.encoded_out), 0);

        // Round-robin rotation over a held all-ones vector
        md = 1; d8 = 8'hFF; d5 = 5'h1F;
        for (int i = 0; i < 9; i++) begin
            step();
            check_val("rr_enc", 32'(if8.encoded_out), rr_exp[i]);
        end

        // Stall: grant 3 held while requests change
        d8 = 8'h08; d5 = 5'h08;
        step();
        check_val("stall_pre", 32'(if8.encoded_out), 3);
        rdy = 0; d8 = 8'h80; d5 = 5'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("stall_enc", 32'(if8.encoded_out), 3);
            check_val("stall_valid", 32'(if8.valid), 1);
        end
        rdy = 1; d8 = 8'hFF; d5 = 5'h1F;
        step();
        // Accepting 3 moves ptr to 2 only now
        check_val("stall_release", 32'(if8.encoded_out), 2);

        // Reset while stalled discards the grant
        rdy = 0; d8 = 8'h01;
        step();
        rn = 0;
        step();
        check_val("midrst_valid", 32'(if8.valid), 0);
        rn = 1;

        // Non-power-of-two wrap on the 5-wide encoder
        md = 1; rdy = 1; d5 = 5'b10001; d8 = 8'h11;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("wrap_enc5", 32'(if5.encoded_out), wrap_exp[i]);
        end

        // Enable low: no grant
        en = 0; d8 = 8'hFF; d5 = 5'h1F;
        step();
        check_val("en_off_valid", 32'(if8.valid), 0);
        en = 1;

        // Randomised traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            rn  = ($urandom_range(0, 49) != 0);
            en  = ($urandom_range(0, 7) != 0);
            md  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            d8  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            d5  = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
            step();
        end

`ifdef PRIO_ENC_COUNT_EN
        // 10 accepted grants, then 3 stalled cycles
        rn = 0; en = 1; md = 0; rdy = 1; d8 = 8'h01; d5 = 5'h01;
        step();
        rn = 1;
        for (int i = 0; i < 11; i++) step();
        rdy = 0;
        for (int i = 0; i < 3; i++) step();
        check_val("cnt_ten", 32'(if8.grant_count), 10);
        rn = 0;
        step();
        check_val("cnt_rst", 32'(if8.grant_count), 0);
        rn = 1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
